// File: rtl/saida_serial_pkg.sv
// Shared state encodings and constant helpers for the multi-character serial output controller.
package saida_serial_pkg;

    typedef enum logic [2:0] {
        INICIAL = 3'd0,
        PARTIDA = 3'd1,
        ESPERA  = 3'd2,
        PROXIMO = 3'd3,
        FIM     = 3'd4,
        ERRO    = 3'd5
    } estado_t;

    // Ceiling log2 usable in parameter expressions; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int rest;
        result = 0;
        rest   = value - 1;
        while (rest > 0) begin
            result = result + 1;
            rest   = rest >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/saida_serial_multi_uc_contador_timeout.sv
// Watchdog counter for time spent waiting on the transmitter; only built when
// SAIDA_SERIAL_TIMEOUT_EN is defined.
`ifdef SAIDA_SERIAL_TIMEOUT_EN
module contador_timeout
    import saida_serial_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic fim
);

    localparam int CNT_W = (clog2(TIMEOUT_CYCLES) < 1) ? 1 : clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LIMITE = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign fim = (cnt_q == LIMITE);

    // Saturates at the limit so fim stays high until the count is cleared.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !fim) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/saida_serial_multi_uc.sv
// Control unit that sequences N_CHARS characters (plus optional terminator) through a serial
// transmitter. Defining SAIDA_SERIAL_TIMEOUT_EN adds a watchdog and the ERRO state.
module saida_serial_multi_uc
    import saida_serial_pkg::*;
#(
    parameter  int N_CHARS        = 3,
    parameter  int TIMEOUT_CYCLES = 50000,
    localparam int IDX_W          = clog2(N_CHARS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inicio,
    input  logic             modo_terminador,
    input  logic             serial_enviado,
    input  logic             cancela,
    output logic [IDX_W-1:0] selecao_mux,
    output logic             partida,
    output logic             proximo,
    output logic             pronto,
    output logic             ocupado,
    output logic             erro,
    output logic [2:0]       db_estado
);

    localparam logic [IDX_W-1:0] ULTIMO_SEM_TERM = IDX_W'(N_CHARS - 1);
    localparam logic [IDX_W-1:0] ULTIMO_COM_TERM = IDX_W'(N_CHARS);

    estado_t          estado_q, estado_d;
    logic [IDX_W-1:0] indice_q, indice_d;
    logic             term_q, term_d;
    logic             partida_q, partida_d;
    logic             proximo_q, proximo_d;
    logic             pronto_q, pronto_d;
    logic             ocupado_q, ocupado_d;
    logic [IDX_W-1:0] ultimo;
    logic             timeout_fim;

`ifdef SAIDA_SERIAL_TIMEOUT_EN
    logic erro_q, erro_d;

    contador_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_contador_timeout (
        .clock (clock),
        .reset (reset),
        .enable(estado_q == ESPERA),
        .clear (estado_q != ESPERA),
        .fim   (timeout_fim)
    );

    assign erro = erro_q;
`else
    assign timeout_fim = 1'b0;
    assign erro        = 1'b0;
`endif

    assign ultimo = term_q ? ULTIMO_COM_TERM : ULTIMO_SEM_TERM;

    always_comb begin
        estado_d = estado_q;
        indice_d = indice_q;
        term_d   = term_q;
        case (estado_q)
            INICIAL: begin
                if (inicio) begin
                    term_d   = modo_terminador;
                    indice_d = '0;
                    estado_d = PARTIDA;
                end
            end
            PARTIDA: estado_d = ESPERA;
            ESPERA: begin
                if (serial_enviado) begin
                    estado_d = (indice_q == ultimo) ? FIM : PROXIMO;
                end else if (timeout_fim) begin
`ifdef SAIDA_SERIAL_TIMEOUT_EN
                    estado_d = ERRO;
`endif
                end
            end
            PROXIMO: begin
                indice_d = indice_q + IDX_W'(1);
                estado_d = PARTIDA;
            end
            FIM: begin
                indice_d = '0;
                estado_d = INICIAL;
            end
`ifdef SAIDA_SERIAL_TIMEOUT_EN
            ERRO: estado_d = ERRO;
`endif
            default: begin
                indice_d = '0;
                estado_d = INICIAL;
            end
        endcase

        // Abort wins over every other transition, including a completed handshake.
        if (cancela && (estado_q != INICIAL)) begin
            estado_d = INICIAL;
            indice_d = '0;
        end

        partida_d = (estado_d == PARTIDA);
        proximo_d = (estado_d == PROXIMO);
        pronto_d  = (estado_d == FIM);
        ocupado_d = (estado_d != INICIAL);
`ifdef SAIDA_SERIAL_TIMEOUT_EN
        erro_d    = (estado_d == ERRO);
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q  <= INICIAL;
            indice_q  <= '0;
            term_q    <= 1'b0;
            partida_q <= 1'b0;
            proximo_q <= 1'b0;
            pronto_q  <= 1'b0;
            ocupado_q <= 1'b0;
`ifdef SAIDA_SERIAL_TIMEOUT_EN
            erro_q    <= 1'b0;
`endif
        end else begin
            estado_q  <= estado_d;
            indice_q  <= indice_d;
            term_q    <= term_d;
            partida_q <= partida_d;
            proximo_q <= proximo_d;
            pronto_q  <= pronto_d;
            ocupado_q <= ocupado_d;
`ifdef SAIDA_SERIAL_TIMEOUT_EN
            erro_q    <= erro_d;
`endif
        end
    end

    assign selecao_mux = indice_q;
    assign partida     = partida_q;
    assign proximo     = proximo_q;
    assign pronto      = pronto_q;
    assign ocupado     = ocupado_q;
    assign db_estado   = estado_q;

endmodule

// File: tb/tb_saida_serial_multi_uc.sv
// Directed, table-driven bench for saida_serial_multi_uc with N_CHARS=3 and TIMEOUT_CYCLES=8.
module tb_saida_serial_multi_uc;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       inicio = 1'b0;
    logic       modo_terminador = 1'b0;
    logic       serial_enviado = 1'b0;
    logic       cancela = 1'b0;
    logic [1:0] selecao_mux;
    logic       partida, proximo, pronto, ocupado, erro;
    logic [2:0] db_estado;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    saida_serial_multi_uc #(
        .N_CHARS       (3),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .inicio         (inicio),
        .modo_terminador(modo_terminador),
        .serial_enviado (serial_enviado),
        .cancela        (cancela),
        .selecao_mux    (selecao_mux),
        .partida        (partida),
        .proximo        (proximo),
        .pronto         (pronto),
        .ocupado        (ocupado),
        .erro           (erro),
        .db_estado      (db_estado)
    );

    typedef struct packed {
        logic       rst_n;
        logic       ini;
        logic       modo;
        logic       env;
        logic       canc;
        logic [2:0] st;
        logic [1:0] sel;
        logic       pa;
        logic       px;
        logic       pr;
        logic       oc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic i, input logic m, input logic e,
                                input logic c, input logic [2:0] st, input logic [1:0] sel,
                                input logic pa, input logic px, input logic pr, input logic oc);
        vec_t v;
        v.rst_n = r; v.ini = i; v.modo = m; v.env = e; v.canc = c;
        v.st = st; v.sel = sel; v.pa = pa; v.px = px; v.pr = pr; v.oc = oc;
        return v;
    endfunction

    function automatic logic [9:0] outs();
        return {db_estado, selecao_mux, partida, proximo, pronto, ocupado, erro};
    endfunction

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got {st,sel,pa,px,pr,oc,er}=%b required=%b", name, got, expv);
        end
    endtask

    task automatic step(input logic r, input logic i, input logic m, input logic e, input logic c);
        reset = r; inicio = i; modo_terminador = m; serial_enviado = e; cancela = c;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;

        // Message without terminator; modo change after latch, stray enviado in PARTIDA,
        // and inicio in ESPERA must all be ignored.
        vecs.push_back(mk(1,1,0,0,0, 3'd1,2'd0, 1,0,0,1));
        vecs.push_back(mk(1,0,1,0,0, 3'd2,2'd0, 0,0,0,1));
        vecs.push_back(mk(1,0,0,0,0, 3'd2,2'd0, 0,0,0,1));
        vecs.push_back(mk(1,0,0,1,0, 3'd3,2'd0, 0,1,0,1));
        vecs.push_back(mk(1,0,0,0,0, 3'd1,2'd1, 1,0,0,1));
        vecs.push_back(mk(1,0,0,1,0, 3'd2,2'd1, 0,0,0,1));
        vecs.push_back(mk(1,1,0,0,0, 3'd2,2'd1, 0,0,0,1));
        vecs.push_back(mk(1,0,0,1,0, 3'd3,2'd1, 0,1,0,1));
        vecs.push_back(mk(1,0,0,0,0, 3'd1,2'd2, 1,0,0,1));
        vecs.push_back(mk(1,0,0,0,0, 3'd2,2'd2, 0,0,0,1));
        vecs.push_back(mk(1,0,0,0,0, 3'd2,2'd2, 0,0,0,1));
        vecs.push_back(mk(1,0,0,1,0, 3'd4,2'd2, 0,0,1,1));
        vecs.push_back(mk(1,0,0,0,0, 3'd0,2'd0, 0,0,0,0));
        // Idle: enviado and cancela have no effect in INICIAL.
        vecs.push_back(mk(1,0,0,1,1, 3'd0,2'd0, 0,0,0,0));
        // Message with terminator, zero-latency handshakes.
        vecs.push_back(mk(1,1,1,0,0, 3'd1,2'd0, 1,0,0,1));
        vecs.push_back(mk(1,0,0,0,0, 3'd2,2'd0, 0,0,0,1));
        vecs.push_back(mk(1,0,0,1,0, 3'd3,2'd0, 0,1,0,1));
        vecs.push_back(mk(1,0,0,0,0, 3'd1,2'd1, 1,0,0,1));
        vecs.push_back(mk(1,0,0,0,0, 3'd2,2'd1, 0,0,0,1));
        vecs.push_back(mk(1,0,0,1,0, 3'd3,2'd1, 0,1,0,1));
        vecs.push_back(mk(1,0,0,0,0, 3'd1,2'd2, 1,0,0,1));
        vecs.push_back(mk(1,0,0,0,0, 3'd2,2'd2, 0,0,0,1));
        vecs.push_back(mk(1,0,0,1,0, 3'd3,2'd2, 0,1,0,1));
        vecs.push_back(mk(1,0,0,0,0, 3'd1,2'd3, 1,0,0,1));
        vecs.push_back(mk(1,0,0,0,0, 3'd2,2'd3, 0,0,0,1));
        vecs.push_back(mk(1,0,0,1,0, 3'd4,2'd3, 0,0,1,1));
        vecs.push_back(mk(1,0,0,0,0, 3'd0,2'd0, 0,0,0,0));
        // Cancel together with enviado at index 1.
        vecs.push_back(mk(1,1,0,0,0, 3'd1,2'd0, 1,0,0,1));
        vecs.push_back(mk(1,0,0,0,0, 3'd2,2'd0, 0,0,0,1));
        vecs.push_back(mk(1,0,0,1,0, 3'd3,2'd0, 0,1,0,1));
        vecs.push_back(mk(1,0,0,0,0, 3'd1,2'd1, 1,0,0,1));
        vecs.push_back(mk(1,0,0,0,0, 3'd2,2'd1, 0,0,0,1));
        vecs.push_back(mk(1,0,0,1,1, 3'd0,2'd0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 3'd0,2'd0, 0,0,0,0));
        // Reset in PROXIMO at index 1, then restart from index 0.
        vecs.push_back(mk(1,1,0,0,0, 3'd1,2'd0, 1,0,0,1));
        vecs.push_back(mk(1,0,0,0,0, 3'd2,2'd0, 0,0,0,1));
        vecs.push_back(mk(1,0,0,1,0, 3'd3,2'd0, 0,1,0,1));
        vecs.push_back(mk(1,0,0,0,0, 3'd1,2'd1, 1,0,0,1));
        vecs.push_back(mk(1,0,0,0,0, 3'd2,2'd1, 0,0,0,1));
        vecs.push_back(mk(1,0,0,1,0, 3'd3,2'd1, 0,1,0,1));
        vecs.push_back(mk(0,1,1,1,0, 3'd0,2'd0, 0,0,0,0));
        vecs.push_back(mk(1,1,0,0,0, 3'd1,2'd0, 1,0,0,1));
        vecs.push_back(mk(1,0,0,0,0, 3'd2,2'd0, 0,0,0,1));
        vecs.push_back(mk(1,0,0,0,1, 3'd0,2'd0, 0,0,0,0));

        // Reset held with busy-looking inputs.
        step(0, 1, 1, 1, 1);
        step(0, 1, 1, 1, 1);
        check("reset_state", outs(), 10'b0);
        $display("reset done st=%0d sel=%0d", db_estado, selecao_mux);

        foreach (vecs[k]) begin
            step(vecs[k].rst_n, vecs[k].ini, vecs[k].modo, vecs[k].env, vecs[k].canc);
            check($sformatf("vec%0d", k), outs(),
                  {vecs[k].st, vecs[k].sel, vecs[k].pa, vecs[k].px, vecs[k].pr, vecs[k].oc, 1'b0});
            $display("vec %0d st=%0d sel=%0d pa=%0d px=%0d pr=%0d oc=%0d",
                     k, db_estado, selecao_mux, partida, proximo, pronto, ocupado);
        end

        // Cancel while in PARTIDA.
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        check("cancel_in_partida", outs(), {3'd0, 2'd0, 5'b00000});
        $display("cancel_in_partida st=%0d sel=%0d", db_estado, selecao_mux);

        // Long wait in ESPERA with no enviado.
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        n = 1;
`ifdef SAIDA_SERIAL_TIMEOUT_EN
        while (!erro && n < 30) begin
            step(1, 0, 0, 0, 0);
            n++;
        end
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL wd_latency erro seen in ESPERA cycle %0d required 9", n);
        end
        check("wd_erro_state", outs(), {3'd5, 2'd0, 5'b00011});
        step(1, 1, 0, 1, 0);
        check("wd_erro_sticky", outs(), {3'd5, 2'd0, 5'b00011});
        step(1, 0, 0, 0, 1);
        check("wd_cancel", outs(), {3'd0, 2'd0, 5'b00000});
        $display("watchdog cycles=%0d st=%0d erro=%0d", n, db_estado, erro);
`else
        while (n < 20) begin
            step(1, 0, 0, 0, 0);
            n++;
        end
        check("long_wait_espera", outs(), {3'd2, 2'd0, 5'b00010});
        step(1, 0, 0, 1, 0);
        check("long_wait_advance", outs(), {3'd3, 2'd0, 5'b01010});
        step(1, 0, 0, 0, 1);
        check("long_wait_cancel", outs(), {3'd0, 2'd0, 5'b00000});
        $display("long wait cycles=%0d st=%0d erro=%0d", n, db_estado, erro);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
